// File: rtl/uart_rx_sampled.sv
// 8N1 UART receiver with a single-byte holding register and new_data/ack handshake.
// Define UART_RX_PARITY_EN to receive 8E1 frames instead (adds a PARITY state).
`timescale 1ns/1ps
module uart_rx_sampled #(
    parameter int INPUT_CLOCK = 16_000_000,
    parameter int BAUD        = 115_200
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_new_data,
    input  logic       i_ack_data,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int CPB  = INPUT_CLOCK / BAUD;
    localparam int HALF = CPB / 2;
    localparam logic [7:0] C_LAST = 8'(CPB - 1);
    localparam logic [7:0] C_HALF = 8'(HALF - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;
`endif

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_rx_prev;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [2:0] r_idx;
    logic [2:0] w_idx_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic [7:0] r_data;
    logic       r_new_data;
    logic       r_frame_err;
    logic       r_overrun;
    logic       w_rx_s;
    logic       w_fall;
    logic       w_last;
    logic       w_deliver;
    logic       w_ferr;
`ifdef UART_RX_PARITY_EN
    logic       r_par_err;
    logic       w_par_err_nxt;
`endif

    assign w_rx_s = r_sync2;
    assign w_fall = r_rx_prev & ~r_sync2;
    assign w_last = (r_cnt == C_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 8'd1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_deliver   = 1'b0;
        w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_err_nxt = r_par_err;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 8'd0;
                if (w_fall) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_cnt == C_HALF) begin
                    w_cnt_nxt   = 8'd0;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_last) begin
                    w_cnt_nxt   = 8'd0;
                    w_shift_nxt = {w_rx_s, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (r_idx == 3'd7) w_state_nxt = S_PARITY;
`else
                    if (r_idx == 3'd7) w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_last) begin
                    w_cnt_nxt     = 8'd0;
                    // even parity: data bits plus parity bit must xor to zero
                    w_par_err_nxt = ^{r_shift, w_rx_s};
                    w_state_nxt   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_last) begin
                    w_cnt_nxt = 8'd0;
                    if (!w_rx_s) begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                    end else if (r_par_err) begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_IDLE;
`endif
                    end else begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_WAIT_HIGH: begin
                w_cnt_nxt = 8'd0;
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = 8'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_cnt       <= 8'd0;
            r_idx       <= 3'd0;
            r_shift     <= 8'd0;
            r_data      <= 8'd0;
            r_new_data  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_sync1     <= i_rx;
            r_sync2     <= r_sync1;
            r_rx_prev   <= r_sync2;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err   <= w_par_err_nxt;
`endif
            // an ack landing with a delivery frees the slot for the new byte
            if (w_deliver) begin
                if (!r_new_data || i_ack_data) begin
                    r_data     <= r_shift;
                    r_new_data <= 1'b1;
                end else begin
                    r_overrun  <= 1'b1;
                end
            end else if (i_ack_data) begin
                r_new_data <= 1'b0;
            end
        end
    end

    assign o_data      = r_data;
    assign o_new_data  = r_new_data;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sampled.sv
// Scoreboard bench for uart_rx_sampled: directed frames, monitor pops expected bytes.
`timescale 1ns/1ps
module tb_uart_rx_sampled;

    localparam int CPB  = 138;
    localparam int HALF = 69;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;
    // start drive -> 2 sync flops + edge register, half bit, then data/parity/stop bits
    localparam int LAT   = 3 + HALF + (NBITS - 1) * CPB;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       ack;
    logic [7:0] data;
    logic       nd;
    logic       ferr;
    logic       ovr;
    logic       busy;

    int n_pass = 0;
    int n_total = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int f0;
    int o0;
    logic [7:0] exp_q[$];
    logic prev_nd = 1'b0;
    logic prev_ack = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic pflip = 1'b0;
`endif

    uart_rx_sampled dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx        (rx),
        .o_data      (data),
        .o_new_data  (nd),
        .i_ack_data  (ack),
        .o_frame_err (ferr),
        .o_overrun   (ovr),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_nd  = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (ferr) ferr_cnt++;
            if (ovr) ovr_cnt++;
            if (nd && (!prev_nd || prev_ack)) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected delivery: got %02h expected none", data);
                end else begin
                    check("rx byte", 32'(data), 32'(exp_q.pop_front()));
                end
            end
            prev_nd  = nd;
            prev_ack = ack;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        cycles(1);
        ack = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ pflip;
        cycles(CPB);
`endif
        rx = stop;
        cycles(CPB);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset data", 32'(data), 32'h00);
        check("reset new_data", 32'(nd), 0);
        check("reset frame_err", 32'(ferr), 0);
        check("reset overrun", 32'(ovr), 0);
        check("reset busy", 32'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cycles(20);

        // reset in the middle of a frame
        rx = 1'b0; cycles(CPB);
        rx = 1'b1; cycles(CPB);
        rx = 1'b0; cycles(100);
        check("busy mid frame", 32'(busy), 1);
        rst = 1'b1;
        rx  = 1'b1;
        cycles(5);
        check("midreset busy", 32'(busy), 0);
        check("midreset new_data", 32'(nd), 0);
        check("midreset data", 32'(data), 32'h00);
        rst = 1'b0;
        cycles(2 * CPB);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        cycles(CPB);
        check("A5 held data", 32'(data), 32'hA5);
        do_ack();
        check("A5 ack clears", 32'(nd), 0);
        cycles(10);

        // single byte, exact latency and hold-until-ack
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (LAT - 1) @(posedge clk);
                @(negedge clk);
                check("latency early", 32'(nd), 0);
                @(negedge clk);
                check("latency", 32'(nd), 1);
            end
        join
        cycles(50);
        check("55 held", 32'(nd), 1);
        check("55 data", 32'(data), 32'h55);
        do_ack();
        check("55 ack clears", 32'(nd), 0);
        cycles(10);

        // glitch shorter than half a bit
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        rx = 1'b0;
        cycles(10);
        check("glitch busy", 32'(busy), 1);
        cycles(30);
        rx = 1'b1;
        cycles(2 * CPB);
        check("glitch idle", 32'(busy), 0);
        check("glitch new_data", 32'(nd), 0);
        check("glitch ferr", 32'(ferr_cnt), 32'(f0));
        check("glitch ovr", 32'(ovr_cnt), 32'(o0));

        // stop bit low, line held low afterwards
        send_frame(8'h3C, 1'b0);
        cycles(CPB);
        check("wait_high busy", 32'(busy), 1);
        check("frame err pulse", 32'(ferr_cnt), 32'(f0 + 1));
        check("frame err no data", 32'(nd), 0);
        rx = 1'b1;
        cycles(CPB);
        check("released idle", 32'(busy), 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        cycles(10);
        check("3C resent", 32'(nd), 1);
        do_ack();
        cycles(10);

        // overrun: two frames back to back, no ack
        o0 = ovr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        cycles(10);
        check("overrun data kept", 32'(data), 32'h11);
        check("overrun new_data", 32'(nd), 1);
        check("overrun pulse", 32'(ovr_cnt), 32'(o0 + 1));
        do_ack();
        cycles(10);

        // ack on the very cycle the second byte is delivered
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                repeat (FRAME + LAT - 1) @(posedge clk);
                #1 ack = 1'b1;
                @(posedge clk);
                #1 ack = 1'b0;
            end
        join
        cycles(10);
        check("race data", 32'(data), 32'h22);
        check("race new_data", 32'(nd), 1);
        check("race no overrun", 32'(ovr_cnt), 32'(o0 + 1));
        do_ack();
        cycles(10);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        cycles(10);
        check("parity ok data", 32'(data), 32'h07);
        do_ack();
        cycles(10);
        f0 = ferr_cnt;
        pflip = 1'b1;
        send_frame(8'h07, 1'b1);
        pflip = 1'b0;
        cycles(10);
        check("parity err pulse", 32'(ferr_cnt), 32'(f0 + 1));
        check("parity err no data", 32'(nd), 0);
`endif

        cycles(20);
        check("queue drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
